// File: rtl/palette_regfile.sv
// Double-buffered colour palette: the host fills a shadow bank at any time,
// and the whole shadow bank is copied into the active bank on a frame
// boundary once a commit has been armed. Pixel lookups read the active bank
// through a two-stage pipeline.
module palette_regfile #(
    parameter int unsigned       DATA_W      = 24,
    parameter int unsigned       NUM_ENTRIES = 4,
    parameter int unsigned       IDX_W       = 2,
    parameter logic [DATA_W-1:0] RESET_COLOR = '0
) (
    input  logic              iclk,
    input  logic              irst_n,
    input  logic              iwe,
    input  logic [IDX_W-1:0]  iwaddr,
    input  logic [DATA_W-1:0] iwdata,
    input  logic              icommit,
    input  logic              ivsync,
    input  logic              ivalid,
    input  logic [IDX_W-1:0]  iridx,
    output logic [DATA_W-1:0] ocolor,
    output logic              ovalid,
    output logic              opending,
    output logic              ocommitted
);

    logic [DATA_W-1:0] shadow [NUM_ENTRIES];
    logic [DATA_W-1:0] active [NUM_ENTRIES];

    logic              vs_d;
    logic              boundary;
    logic              do_copy;

    logic              s1_valid;
    logic [IDX_W-1:0]  s1_idx;
    logic [DATA_W-1:0] rd_color;

    // Frame-boundary detect, copy decision and active-bank read mux.
    // Indices without a backing entry fall through to the zero default.
    always_comb begin
        boundary = ivsync & ~vs_d;
        do_copy  = boundary & opending;
        rd_color = '0;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (s1_idx == IDX_W'(i)) begin
                rd_color = active[i];
            end
        end
    end

    // Remember the previous vsync level for edge detection.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            vs_d <= 1'b0;
        end else begin
            vs_d <= ivsync;
        end
    end

    // Host writes into the shadow bank; out-of-range addresses match no entry.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                shadow[i] <= RESET_COLOR;
            end
        end else if (iwe) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (iwaddr == IDX_W'(i)) begin
                    shadow[i] <= iwdata;
                end
            end
        end
    end

    // Whole-bank copy at an armed boundary; non-blocking read of shadow
    // means a same-edge host write is not seen by this copy.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                active[i] <= RESET_COLOR;
            end
        end else if (do_copy) begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                active[i] <= shadow[i];
            end
        end
    end

    // Commit arming and the one-cycle "committed" pulse. A commit that
    // arrives on the same edge as an unarmed boundary only arms.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            opending   <= 1'b0;
            ocommitted <= 1'b0;
        end else begin
            ocommitted <= do_copy;
            if (do_copy) begin
                opending <= 1'b0;
            end else if (icommit) begin
                opending <= 1'b1;
            end
        end
    end

    // Lookup stage 1: capture request.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
        end else begin
            s1_valid <= ivalid;
            s1_idx   <= iridx;
        end
    end

    // Lookup stage 2: read active bank as it stood before this edge;
    // colour holds when no request is in flight.
    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            ovalid <= 1'b0;
            ocolor <= '0;
        end else begin
            ovalid <= s1_valid;
            if (s1_valid) begin
                ocolor <= rd_color;
            end
        end
    end

endmodule

// File: doc/palette_regfile.md
PALETTE_REGFILE -- requirements
Module: palette_regfile

Interface
REQ-001 Parameter DATA_W, default 24: width of one colour entry (RGB888).
REQ-002 Parameter NUM_ENTRIES, default 4: number of palette entries, range 2..256.
REQ-003 Parameter IDX_W, default 2: index width; SHALL satisfy 2**IDX_W >= NUM_ENTRIES.
REQ-004 Parameter RESET_COLOR, default 24'h000000: reset value of every entry.
REQ-005 iclk  in  1  sole clock; all state changes on rising edge.
REQ-006 irst_n  in  1  asynchronous, active-low reset.
REQ-007 iwe  in  1  shadow-bank write enable.
REQ-008 iwaddr  in  IDX_W  shadow write index.
REQ-009 iwdata  in  DATA_W  shadow write data.
REQ-010 icommit  in  1  request to copy the shadow bank into the active bank at the next frame boundary.
REQ-011 ivsync  in  1  frame sync level; a frame boundary is its 0->1 transition.
REQ-012 ivalid  in  1  pixel lookup request.
REQ-013 iridx  in  IDX_W  pixel palette index.
REQ-014 ocolor  out  DATA_W  looked-up colour from the active bank.
REQ-015 ovalid  out  1  ocolor is valid this cycle.
REQ-016 opending  out  1  a commit is armed and waiting for a frame boundary.
REQ-017 ocommitted  out  1  one-cycle pulse on the cycle after the active bank is updated.

Function
REQ-018 Two banks of NUM_ENTRIES x DATA_W registers SHALL exist: shadow (written by host) and active (read by the pixel path).
REQ-019 iwe=1 with iwaddr<NUM_ENTRIES SHALL write iwdata into shadow[iwaddr] at the edge; iwaddr>=NUM_ENTRIES SHALL be ignored.
REQ-020 The block SHALL register ivsync once (vs_d); boundary = ivsync & ~vs_d.
REQ-021 icommit=1 with opending=0 SHALL set opending at the edge; icommit while opending=1 SHALL have no effect.
REQ-022 At a boundary with opending=1, all active entries SHALL load the shadow contents in one edge, opending SHALL clear, and ocommitted SHALL be 1 for the following cycle only.
REQ-023 Same-cycle shadow write and commit copy: the active bank SHALL receive the pre-write shadow value; the write SHALL still land in shadow.
REQ-024 Same-cycle icommit and boundary with opending=0: opending SHALL be set, and the copy SHALL wait for the next boundary.
REQ-025 Lookup SHALL be a 2-stage pipeline: edge N registers iridx and ivalid; edge N+1 drives ocolor=active[idx] and ovalid=ivalid from edge N; latency is 2 cycles, throughput 1 per cycle.
REQ-026 Stage 2 SHALL read the active bank as held immediately before edge N+1, so a commit at edge N+1 is visible only to lookups issued one cycle later.
REQ-027 An index >= NUM_ENTRIES SHALL produce ocolor=0 with ovalid=1.
REQ-028 When the stage-2 valid is 0, ovalid SHALL be 0 and ocolor SHALL hold its previous value.
REQ-029 The active bank SHALL change only through REQ-022.

Reset
REQ-030 While irst_n=0, regardless of iclk: both banks = RESET_COLOR, opending=0, ocommitted=0, ovalid=0, ocolor=0, vs_d=0, pipeline valid=0.
REQ-031 A reset asserted while opending=1 SHALL cancel the armed commit.
REQ-032 After reset release, a first-cycle ivsync=1 counts as a boundary but SHALL have no effect because opending=0.

Verification
REQ-033 Reset, then write shadow[1]=24'hFF0000 with no commit, then lookup idx 1 -> ocolor=24'h000000, ovalid=1, 2 cycles after ivalid.
REQ-034 Write shadow[0..3]=24'h111111/222222/333333/444444, pulse icommit, then pulse ivsync -> opending=1 until the boundary, ocommitted pulses once, and lookups 0..3 back-to-back return the four values on consecutive cycles.
REQ-035 With opending=1, write shadow[2]=24'hABCDEF on the boundary cycle -> active[2] keeps its old value and shadow[2]=24'hABCDEF; a second commit and boundary make active[2]=24'hABCDEF.
REQ-036 With NUM_ENTRIES=3, IDX_W=2: iwaddr=3 write is ignored; lookup idx 3 -> ocolor=0, ovalid=1.
REQ-037 Assert icommit, drop irst_n for 1 cycle before the boundary, then pulse ivsync -> no copy, ocommitted stays 0, opending=0.
REQ-038 Hold icommit high for 3 cycles with ivsync rising on the 2nd cycle -> exactly one copy, at that boundary (opending was set on the 1st cycle), and opending is set again by the 3rd-cycle icommit.
